run_controller: RTL and testbench

- Parametrised run-control sequencer for the 9-bit-ISA core; replaces the ad-hoc ever_start/start_off/cycle-counter logic in the top level.
- Implements the testbench start/ack handshake and selects one of NUM_PROGS program entry points.
- Drives PC load and the instruction gate (run_en low forces NOP), counts run cycles, and ends a run on done_in or on a watchdog limit.

---
 rtl/run_ctrl_pkg.sv | 13 +
 rtl/run_controller_sat_counter.sv | 33 +++
 rtl/run_controller.sv | 168 ++++++++++++++++
 tb/tb_run_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run-control sequencer.
package run_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, RUN, DONE, TIMEOUT} run_state_e;

  localparam int unsigned RUN_CTRL_CYCLE_LIMIT_DEFAULT = 4096;

  // Width of a program index; a single program still needs one select bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_controller.sv
// Run-control sequencer: start/ack handshake, entry-PC select, run gating and watchdog.
// Optional statistics (instr_count, runs_done) are built when RUN_CTRL_STATS_EN is defined.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned NUM_PROGS   = 4,
  parameter int unsigned SEL_W       = sel_width(NUM_PROGS),
  parameter int unsigned CYCLE_W     = 16,
  parameter int unsigned CYCLE_LIMIT = RUN_CTRL_CYCLE_LIMIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SEL_W-1:0]          prog_sel,
  input  logic [NUM_PROGS*PC_W-1:0] pc_base,
  input  logic                      done_in,
`ifdef RUN_CTRL_STATS_EN
  input  logic                      instr_valid,
  output logic [CYCLE_W-1:0]        instr_count,
  output logic [7:0]                runs_done,
`endif
  output logic                      pc_load,
  output logic [PC_W-1:0]           pc_load_val,
  output logic                      run_en,
  output logic                      ack,
  output logic                      timeout,
  output logic [CYCLE_W-1:0]        cycle_count
);

  localparam logic [CYCLE_W-1:0] LimitM1 = CYCLE_W'(CYCLE_LIMIT - 1);

  run_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [PC_W-1:0]  pc_val_q, pc_val_d;
  logic             pc_load_q, pc_load_d;
  logic             run_en_q, run_en_d;
  logic             ack_q, ack_d;
  logic             timeout_q, timeout_d;
  logic             cnt_clr, cnt_inc, at_limit, launch;
  logic [CYCLE_W-1:0] cycle_cnt;

  assign at_limit = (cycle_cnt == LimitM1);
  assign cnt_inc  = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          cnt_clr = 1'b1;
        end
      end
      ARMED: begin
        if (!start) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      RUN: begin
        // A done seen on the limit cycle still counts as a clean finish.
        if (done_in) begin
          state_d = DONE;
        end else if (at_limit) begin
          state_d = TIMEOUT;
        end
      end
      DONE, TIMEOUT: begin
        if (start) begin
          state_d = ARMED;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry-PC mux; out-of-range program indices fall back to program 0.
  always_comb begin
    sel_d    = sel_q;
    pc_val_d = pc_val_q;
    if (launch) begin
      sel_d    = (32'(prog_sel) < NUM_PROGS) ? prog_sel : '0;
      pc_val_d = pc_base[PC_W-1:0];
      for (int unsigned i = 0; i < NUM_PROGS; i++) begin
        if (sel_d == SEL_W'(i)) begin
          pc_val_d = pc_base[i*PC_W +: PC_W];
        end
      end
    end
  end

  always_comb begin
    pc_load_d = launch;
    run_en_d  = (state_d == RUN);
    ack_d     = (state_d == DONE) || (state_d == TIMEOUT);
    timeout_d = (state_d == TIMEOUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      pc_val_q  <= '0;
      pc_load_q <= 1'b0;
      run_en_q  <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pc_val_q  <= pc_val_d;
      pc_load_q <= pc_load_d;
      run_en_q  <= run_en_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .W(CYCLE_W)
  ) u_cycle_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cycle_cnt)
  );

`ifdef RUN_CTRL_STATS_EN
  logic       instr_inc;
  logic [7:0] runs_q, runs_d;

  assign instr_inc = (state_q == RUN) && instr_valid;
  assign runs_d    = (state_q == RUN && done_in) ? runs_q + 8'd1 : runs_q;

  sat_counter #(
    .W(CYCLE_W)
  ) u_instr_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (instr_inc),
    .cnt  (instr_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      runs_q <= '0;
    end else begin
      runs_q <= runs_d;
    end
  end

  assign runs_done = runs_q;
`endif

  assign pc_load     = pc_load_q;
  assign pc_load_val = pc_val_q;
  assign run_en      = run_en_q;
  assign ack         = ack_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_cnt;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: vector table, random runs and reset corner cases.
module tb_run_controller;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned NPROG   = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CYC_W   = 16;
  localparam int          LIMIT   = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [SEL_W-1:0]       prog_sel;
  logic [NPROG*PC_W-1:0]  pc_base;
  logic                   done_in;
  logic                   pc_load;
  logic [PC_W-1:0]        pc_load_val;
  logic                   run_en;
  logic                   ack;
  logic                   timeout;
  logic [CYC_W-1:0]       cycle_count;
`ifdef RUN_CTRL_STATS_EN
  logic                   instr_valid;
  logic [CYC_W-1:0]       instr_count;
  logic [7:0]             runs_done;
  int                     exp_instr;
  int                     exp_runs;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] pc_words [NPROG];
  logic        park_ack, park_to;
  int          park_cnt;

  typedef struct {
    int          sel;
    int          done_at;
    bit          glitch;
    logic [31:0] exp_pc;
    int          exp_cycles;
    bit          exp_to;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  run_controller #(
    .PC_W       (PC_W),
    .NUM_PROGS  (NPROG),
    .SEL_W      (SEL_W),
    .CYCLE_W    (CYC_W),
    .CYCLE_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_sel   (prog_sel),
    .pc_base    (pc_base),
    .done_in    (done_in),
`ifdef RUN_CTRL_STATS_EN
    .instr_valid(instr_valid),
    .instr_count(instr_count),
    .runs_done  (runs_done),
`endif
    .pc_load    (pc_load),
    .pc_load_val(pc_load_val),
    .run_en     (run_en),
    .ack        (ack),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a run lasts done_at cycles if done arrives within the limit, else LIMIT cycles.
  function automatic int model_cycles(input int done_at);
    return (done_at >= 1 && done_at <= LIMIT) ? done_at : LIMIT;
  endfunction

  function automatic bit model_to(input int done_at);
    return !(done_at >= 1 && done_at <= LIMIT);
  endfunction

  task automatic do_run(input int sel, input int done_at, input bit glitch,
                        input logic [31:0] exp_pc, input int exp_cycles, input bit exp_to);
    bit v;
    // Spurious done while parked must change nothing.
    done_in = 1'b1;
    @(negedge clk);
    chk("park_ack", ack, park_ack);
    chk("park_timeout", timeout, park_to);
    chk("park_cnt", cycle_count, park_cnt);
    chk("park_run_en", run_en, 0);
    done_in = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    chk("armed_ack", ack, 0);
    chk("armed_timeout", timeout, 0);
    chk("armed_cnt", cycle_count, 0);
    chk("armed_run_en", run_en, 0);
    done_in = 1'b1;
`ifdef RUN_CTRL_STATS_EN
    instr_valid = 1'b1;
`endif
    @(negedge clk);
    chk("armed2_ack", ack, 0);
    chk("armed2_run_en", run_en, 0);
    chk("armed2_pc_load", pc_load, 0);
    done_in  = 1'b0;
    start    = 1'b0;
    prog_sel = SEL_W'(sel);
`ifdef RUN_CTRL_STATS_EN
    exp_instr = 0;
    v = 1'($urandom_range(0, 1));
    instr_valid = v;
    exp_instr += int'(v);
`endif
    for (int k = 1; k <= exp_cycles; k++) begin
      @(negedge clk);
      chk($sformatf("run_en_c%0d", k), run_en, 1);
      chk($sformatf("pc_load_c%0d", k), pc_load, (k == 1));
      chk($sformatf("pc_val_c%0d", k), pc_load_val, exp_pc);
      chk($sformatf("cnt_c%0d", k), cycle_count, k - 1);
      chk($sformatf("run_ack_c%0d", k), ack, 0);
      prog_sel = SEL_W'($urandom_range(0, NPROG - 1));
      done_in  = (k == done_at);
      start    = glitch && (k % 2 == 0);
`ifdef RUN_CTRL_STATS_EN
      v = (k < exp_cycles) ? 1'($urandom_range(0, 1)) : 1'b0;
      instr_valid = v;
      exp_instr += int'(v);
`endif
    end
    @(negedge clk);
    start   = 1'b0;
    done_in = 1'b0;
    chk("end_run_en", run_en, 0);
    chk("end_ack", ack, 1);
    chk("end_timeout", timeout, exp_to);
    chk("end_cnt", cycle_count, exp_cycles);
    chk("end_pc_load", pc_load, 0);
    chk("end_pc_val", pc_load_val, exp_pc);
`ifdef RUN_CTRL_STATS_EN
    if (!exp_to) exp_runs++;
    chk("instr_count", instr_count, exp_instr);
    chk("runs_done", runs_done, exp_runs);
`endif
    park_ack = 1'b1;
    park_to  = exp_to;
    park_cnt = exp_cycles;
  endtask

  initial begin
    pc_words[0] = 32'h10;
    pc_words[1] = 32'h80;
    pc_words[2] = 32'h40;
    pc_words[3] = 32'hC0;
    pc_base  = {pc_words[3], pc_words[2], pc_words[1], pc_words[0]};
    reset    = 1'b0;
    start    = 1'b0;
    done_in  = 1'b0;
    prog_sel = '0;
`ifdef RUN_CTRL_STATS_EN
    instr_valid = 1'b0;
    exp_runs    = 0;
`endif
    park_ack = 1'b0;
    park_to  = 1'b0;
    park_cnt = 0;

    vecs[0] = '{2, 10, 1'b0, 32'h40, 10, 1'b0};  // basic run
    vecs[1] = '{2,  0, 1'b0, 32'h40, 16, 1'b1};  // watchdog
    vecs[2] = '{3, 16, 1'b0, 32'hC0, 16, 1'b0};  // done on limit cycle
    vecs[3] = '{1,  5, 1'b1, 32'h80,  5, 1'b0};  // re-arm, start ignored in RUN
    vecs[4] = '{0,  1, 1'b0, 32'h10,  1, 1'b0};  // done on first cycle
    vecs[5] = '{3, 17, 1'b1, 32'hC0, 16, 1'b1};  // done too late
    vecs[6] = '{1, 15, 1'b0, 32'h80, 15, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pc_val", pc_load_val, 0);
    chk("rst_run_en", run_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cnt", cycle_count, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_run_en", run_en, 0);
    chk("idle_ack", ack, 0);

    foreach (vecs[i]) begin
      do_run(vecs[i].sel, vecs[i].done_at, vecs[i].glitch,
             vecs[i].exp_pc, vecs[i].exp_cycles, vecs[i].exp_to);
    end

    for (int r = 0; r < 12; r++) begin
      int s, d;
      bit g;
      s = int'($urandom_range(0, NPROG - 1));
      d = int'($urandom_range(0, LIMIT + 4));
      g = 1'($urandom_range(0, 1));
      do_run(s, d, g, pc_words[s], model_cycles(d), model_to(d));
    end

    // Reset asserted between edges in RUN cycle 5.
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    prog_sel = 2'd1;
    repeat (5) @(negedge clk);
    chk("mid_run_en", run_en, 1);
    chk("mid_cnt", cycle_count, 4);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_run_en", run_en, 0);
    chk("mid_rst_pc_load", pc_load, 0);
    chk("mid_rst_cnt", cycle_count, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_pc_val", pc_load_val, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_run_en", run_en, 0);
    chk("post_rst_ack", ack, 0);
    park_ack = 1'b0;
    park_to  = 1'b0;
    park_cnt = 0;
`ifdef RUN_CTRL_STATS_EN
    exp_runs = 0;
    chk("post_rst_runs", runs_done, 0);
`endif
    do_run(2, 10, 1'b0, pc_words[2], 10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
